spi_shift_reg: RTL

Serial data engine of the SPI master. Sits directly downstream of the baud-rate generator: it consumes that block's pre-edge strobes (`flag_low`, `flag_high`, `flags_low`, `flags_high`) together with `cpol`/`cphase`/`ss`, and uses them to drive MOSI, capture MISO, and hand a completed word back to the register interface. One word is transferred per `ss` assertion.

---
 rtl/spi_shift_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_shift_reg.sv
// SPI master serial engine: drives MOSI, captures MISO and returns one word per slave-select window.
// Optional build macro SPI_SHIFT_LOOPBACK_EN feeds the receive path from the mosi register instead of the miso pin.
module spi_shift_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  ss,
  input  logic                  cpol,
  input  logic                  cphase,
  input  logic                  lsbfe,
  input  logic                  send_data,
  input  logic [DATA_WIDTH-1:0] data_mosi,
  input  logic                  miso,
  input  logic                  flag_low,
  input  logic                  flag_high,
  input  logic                  flags_low,
  input  logic                  flags_high,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] data_miso,
  output logic                  receive_data,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  order;
  logic [CNT_W-1:0]      cnt;
  logic                  lead_s, trail_s, lead_d, trail_d;
  logic                  sample_stb, drive_stb, last_bit, rx_in;

  function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] word,
                                    input logic                  lsb_first,
                                    input logic [IDX_W-1:0]      idx);
    logic [IDX_W-1:0] msb_idx;
    msb_idx = IDX_W'(DATA_WIDTH - 1) - idx;
    return lsb_first ? word[idx] : word[msb_idx];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] word,
                                                     input logic                  lsb_first,
                                                     input logic                  din);
    return lsb_first ? {din, word[DATA_WIDTH-1:1]} : {word[DATA_WIDTH-2:0], din};
  endfunction

`ifdef SPI_SHIFT_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_in       = mosi;
`else
  assign rx_in       = miso;
`endif

  always_comb begin
    lead_s     = cpol ? flag_high  : flag_low;
    trail_s    = cpol ? flag_low   : flag_high;
    lead_d     = cpol ? flags_high : flags_low;
    trail_d    = cpol ? flags_low  : flags_high;
    sample_stb = cphase ? trail_s : lead_s;
    drive_stb  = cphase ? lead_d : (trail_d && (cnt < CNT_W'(DATA_WIDTH)));
    last_bit   = (cnt == CNT_W'(DATA_WIDTH - 1));
    rx_next    = rx_shift(rx_reg, order, rx_in);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state        <= IDLE;
      tx_reg       <= '0;
      rx_reg       <= '0;
      order        <= 1'b0;
      cnt          <= '0;
      mosi         <= 1'b0;
      data_miso    <= '0;
      receive_data <= 1'b0;
      busy         <= 1'b0;
    end else begin
      receive_data <= 1'b0;
      case (state)
        IDLE: begin
          if (send_data) begin
            tx_reg <= data_mosi;
            order  <= lsbfe;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= LOADED;
          end
        end
        LOADED: begin
          if (ss) begin
            state <= IDLE;
            busy  <= 1'b0;
            mosi  <= 1'b0;
          end else begin
            state <= SHIFT;
            // CPHA=0 needs the first bit on the line before the first leading edge
            if (!cphase) mosi <= pick_bit(tx_reg, order, '0);
          end
        end
        SHIFT: begin
          if (ss) begin
            state <= IDLE;
            busy  <= 1'b0;
            mosi  <= 1'b0;
          end else if (sample_stb) begin
            rx_reg <= rx_next;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
              data_miso    <= rx_next;
              receive_data <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end
          end else if (drive_stb) begin
            // cnt equals the number of bits already sampled, i.e. the index of the next bit out
            mosi <= pick_bit(tx_reg, order, cnt[IDX_W-1:0]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
